// File: rtl/spi_shift_engine.sv
// spi_shift_engine: parametrised SPI serialiser/deserialiser for the APB-SPI datapath.
// A DATA_W-bit word is loaded and shifted out on MOSI. At the same time a DATA_W-bit
// word is assembled from MISO. Both are paced by per-edge strobes from the baud generator.
//
// Ports:
//   PCLK, PRESET          system clock, asynchronous active-high reset
//   ss_i                  slave select (active low); high aborts a transfer
//   cpol_i, cphase_i      SPI mode, latched at load
//   lsbfe_i               1 = LSB first, latched at load
//   send_data_i           one-cycle load request for data_mosi_i
//   miso_i                serial input
//   mosi_send_sclk*_i     tx strobes (sclk: modes 0/3, sclk0: modes 1/2)
//   miso_receive_sclk*_i  rx strobes (sclk: modes 0/3, sclk0: modes 1/2)
//   loopback_i            (SPI_LOOPBACK_EN only) rx samples registered mosi_o
//   mosi_o                serial output, IDLE_MOSI when not busy
//   data_miso_o           last complete received word
//   rx_valid_o            one-cycle pulse when data_miso_o updates
//   busy_o                transfer in progress
//   load_err_o            one-cycle pulse when a load is rejected mid-transfer
//
// Optional feature: define SPI_LOOPBACK_EN to add loopback_i.
module spi_shift_engine #(
   parameter int unsigned DATA_W    = 8,
   parameter logic        IDLE_MOSI = 1'b0
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              ss_i,
   input  logic              cpol_i,
   input  logic              cphase_i,
   input  logic              lsbfe_i,
   input  logic              send_data_i,
   input  logic [DATA_W-1:0] data_mosi_i,
   input  logic              miso_i,
`ifdef SPI_LOOPBACK_EN
   input  logic              loopback_i,
`endif
   input  logic              mosi_send_sclk_i,
   input  logic              mosi_send_sclk0_i,
   input  logic              miso_receive_sclk_i,
   input  logic              miso_receive_sclk0_i,
   output logic              mosi_o,
   output logic [DATA_W-1:0] data_miso_o,
   output logic              rx_valid_o,
   output logic              busy_o,
   output logic              load_err_o
);

   localparam int unsigned CNT_W   = $clog2(DATA_W);
   // tx counter needs one extra bit so it can sit at DATA_W and ignore surplus strobes
   localparam int unsigned TxCntW  = CNT_W + 1;

   typedef enum logic [0:0] {StIdle, StXfer} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic [DATA_W-1:0]   data_miso_q, data_miso_d;
   logic [TxCntW-1:0]   tx_cnt_q, tx_cnt_d;
   logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
   logic                mode_q, mode_d;
   logic                lsb_q, lsb_d;
   logic                mosi_q, mosi_d;
   logic                rx_valid_q, rx_valid_d;
   logic                load_err_q, load_err_d;

   logic                tx_stb, rx_stb, rx_bit, load_ok, last_rx;
   logic [CNT_W-1:0]    tx_idx, rx_idx;
   logic [DATA_W-1:0]   rx_word;

   function automatic logic [CNT_W-1:0] bit_idx(input logic lsb, input logic [CNT_W-1:0] cnt);
      return lsb ? cnt : CNT_W'(DATA_W - 1) - cnt;
   endfunction

   // Latched mode picks which strobe pair drives the shifter
   assign tx_stb  = mode_q ? mosi_send_sclk0_i    : mosi_send_sclk_i;
   assign rx_stb  = mode_q ? miso_receive_sclk0_i : miso_receive_sclk_i;
   assign tx_idx  = bit_idx(lsb_q, tx_cnt_q[CNT_W-1:0]);
   assign rx_idx  = bit_idx(lsb_q, rx_cnt_q);
   assign load_ok = send_data_i && !ss_i;
   assign last_rx = rx_stb && (rx_cnt_q == CNT_W'(DATA_W - 1));

`ifdef SPI_LOOPBACK_EN
   assign rx_bit = loopback_i ? mosi_q : miso_i;
`else
   assign rx_bit = miso_i;
`endif

   always_comb begin
      state_d     = state_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      data_miso_d = data_miso_q;
      tx_cnt_d    = tx_cnt_q;
      rx_cnt_d    = rx_cnt_q;
      mode_d      = mode_q;
      lsb_d       = lsb_q;
      mosi_d      = mosi_q;
      rx_valid_d  = 1'b0;
      load_err_d  = 1'b0;
      rx_word     = rx_q;
      rx_word[rx_idx] = rx_bit;

      unique case (state_q)
         StIdle: begin
            if (load_ok) begin
               state_d  = StXfer;
               tx_d     = data_mosi_i;
               mode_d   = cpol_i ^ cphase_i;
               lsb_d    = lsbfe_i;
               tx_cnt_d = '0;
               rx_cnt_d = '0;
            end
         end
         StXfer: begin
            if (ss_i) begin
               state_d  = StIdle;
               tx_cnt_d = '0;
               rx_cnt_d = '0;
               mosi_d   = IDLE_MOSI;
            end else begin
               if (tx_stb && (tx_cnt_q < TxCntW'(DATA_W))) begin
                  mosi_d   = tx_q[tx_idx];
                  tx_cnt_d = tx_cnt_q + TxCntW'(1);
               end
               if (rx_stb) begin
                  rx_d     = rx_word;
                  rx_cnt_d = rx_cnt_q + CNT_W'(1);
               end
               if (last_rx) begin
                  // Completion overrides any tx shift in the same cycle
                  data_miso_d = rx_word;
                  rx_valid_d  = 1'b1;
                  mosi_d      = IDLE_MOSI;
                  tx_cnt_d    = '0;
                  rx_cnt_d    = '0;
                  if (load_ok) begin
                     tx_d   = data_mosi_i;
                     mode_d = cpol_i ^ cphase_i;
                     lsb_d  = lsbfe_i;
                  end else begin
                     state_d = StIdle;
                  end
               end else if (send_data_i) begin
                  load_err_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q     <= StIdle;
         tx_q        <= '0;
         rx_q        <= '0;
         data_miso_q <= '0;
         tx_cnt_q    <= '0;
         rx_cnt_q    <= '0;
         mode_q      <= 1'b0;
         lsb_q       <= 1'b0;
         mosi_q      <= IDLE_MOSI;
         rx_valid_q  <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         data_miso_q <= data_miso_d;
         tx_cnt_q    <= tx_cnt_d;
         rx_cnt_q    <= rx_cnt_d;
         mode_q      <= mode_d;
         lsb_q       <= lsb_d;
         mosi_q      <= mosi_d;
         rx_valid_q  <= rx_valid_d;
         load_err_q  <= load_err_d;
      end
   end

   assign mosi_o      = mosi_q;
   assign data_miso_o = data_miso_q;
   assign rx_valid_o  = rx_valid_q;
   assign busy_o      = (state_q == StXfer);
   assign load_err_o  = load_err_q;

endmodule
